// File: rtl/verdict_collector_pkg.sv
// Shared types and header layout for the verdict collector.
// The serializer state enum and the 64-bit header packing live here.
package verdict_collector_pkg;

    localparam int DROP_W = 8;

    localparam int HDR_MASK_LSB = 0;
    localparam int HDR_POP_LSB  = 16;
    localparam int HDR_DROP_LSB = 24;
    localparam int HDR_TS_LSB   = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HDR,
        DATA
    } ser_state_t;

    function automatic logic [63:0] make_header(
        input logic [31:0] ts,
        input logic [7:0]  drops,
        input logic [7:0]  pop,
        input logic [15:0] mask
    );
        logic [63:0] w;
        w = '0;
        w[HDR_TS_LSB   +: 32] = ts;
        w[HDR_DROP_LSB +: 8]  = drops;
        w[HDR_POP_LSB  +: 8]  = pop;
        w[HDR_MASK_LSB +: 16] = mask;
        return w;
    endfunction

endpackage

// File: rtl/verdict_collector_fifo.sv
// Record FIFO for the verdict collector: first-word-fall-through read,
// pointers reset asynchronously, storage left unreset.
module verdict_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/verdict_collector.sv
// Captures active monitor output cycles with a timestamp, buffers them and
// streams each record out as a header word followed by one word per active stream.
module verdict_collector
    import verdict_collector_pkg::*;
#(
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 64,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic [NUM_OUT-1:0]        out_aktv,
    output logic [63:0]               m_data,
    output logic                      m_valid,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic                      overflow
);

    typedef struct packed {
        logic [TS_W-1:0]           ts;
        logic [NUM_OUT-1:0]        mask;
        logic [NUM_OUT*DATA_W-1:0] data;
        logic [DROP_W-1:0]         drops;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    logic [TS_W-1:0]    ts;
    logic [DROP_W-1:0]  drop_cnt;
    rec_t               wr_rec;
    rec_t               rd_rec;
    rec_t               hold;
    logic [NUM_OUT-1:0] rem_mask;
    logic [NUM_OUT-1:0] rem_next;
    logic [DATA_W-1:0]  sel_word;
    logic [7:0]         pop_cnt;
    logic [63:0]        hdr_word;
    ser_state_t         state;
    logic               capture;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;

    assign capture = en && (|out_aktv);
    assign push    = capture && !fifo_full;
    assign pop     = (state == IDLE) && !fifo_empty;
    assign wr_rec  = '{ts: ts, mask: out_aktv, data: out_data, drops: drop_cnt};

    verdict_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_rec),
        .pop   (pop),
        .rdata (rd_rec),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The drop count rides along with the next record that fits, then restarts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts       <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (en)
                ts <= ts + TS_W'(1);
            if (push) begin
                drop_cnt <= '0;
            end else if (capture) begin
                overflow <= 1'b1;
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--)
            if (rem_mask[i])
                sel_word = hold.data[i*DATA_W +: DATA_W];
    end

    assign rem_next = rem_mask & (rem_mask - NUM_OUT'(1));

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_OUT; i++)
            pop_cnt = pop_cnt + 8'(hold.mask[i]);
    end

    assign hdr_word = make_header(32'(hold.ts), hold.drops, pop_cnt, 16'(hold.mask));

    // rem_mask tracks the streams still to be sent; the lowest set bit goes next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hold     <= '0;
            rem_mask <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        hold  <= rd_rec;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    m_valid  <= 1'b1;
                    m_last   <= 1'b0;
                    m_data   <= hdr_word;
                    rem_mask <= hold.mask;
                    state    <= HDR;
                end
                HDR: begin
                    if (m_ready) begin
                        m_data   <= sel_word;
                        m_last   <= (rem_next == '0);
                        rem_mask <= rem_next;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (m_ready) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            m_data  <= '0;
                            state   <= IDLE;
                        end else begin
                            m_data   <= sel_word;
                            m_last   <= (rem_next == '0);
                            rem_mask <= rem_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_verdict_collector.sv
// Self-checking bench for verdict_collector: a 32-bit and an 8-bit timestamp
// instance share stimulus; accepted words are compared against a record-level model.
module tb_verdict_collector;

    localparam int NUM_OUT = 4;
    localparam int DATA_W  = 64;
    localparam int DEPTH   = 8;
    localparam int DW      = NUM_OUT * DATA_W;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               m_ready = 1'b0;
    logic [DW-1:0]      out_data = '0;
    logic [NUM_OUT-1:0] out_aktv = '0;
    logic [63:0]        m_data, m_data8;
    logic               m_valid, m_last, overflow;
    logic               m_valid8, m_last8, overflow8;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [64:0] got_q[$];
    logic [64:0] got8_q[$];
    logic [64:0] exp_q[$];
    logic [64:0] exp8_q[$];
    logic [31:0] ts_model = '0;
    logic [7:0]  drop_model = '0;

    verdict_collector #(
        .NUM_OUT (NUM_OUT), .DATA_W (DATA_W), .TS_W (32), .DEPTH (DEPTH)
    ) dut (
        .clk (clk), .rst (rst), .en (en), .out_data (out_data), .out_aktv (out_aktv),
        .m_data (m_data), .m_valid (m_valid), .m_last (m_last), .m_ready (m_ready),
        .overflow (overflow)
    );

    verdict_collector #(
        .NUM_OUT (NUM_OUT), .DATA_W (DATA_W), .TS_W (8), .DEPTH (DEPTH)
    ) dut8 (
        .clk (clk), .rst (rst), .en (en), .out_data (out_data), .out_aktv (out_aktv),
        .m_data (m_data8), .m_valid (m_valid8), .m_last (m_last8), .m_ready (m_ready),
        .overflow (overflow8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && m_valid && m_ready)
            got_q.push_back({m_last, m_data});
        if (rst && m_valid8 && m_ready)
            got8_q.push_back({m_last8, m_data8});
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++)
            d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Reference: a record becomes a header then the active streams in ascending order.
    task automatic expect_record(input logic [31:0] ts, input logic [NUM_OUT-1:0] mask,
                                 input logic [DW-1:0] data, input logic [7:0] drops);
        int k;
        int seen;
        k = $countones(mask);
        seen = 0;
        exp_q.push_back({1'b0, ts, drops, 8'(k), 16'(mask)});
        exp8_q.push_back({1'b0, 24'd0, ts[7:0], drops, 8'(k), 16'(mask)});
        for (int i = 0; i < NUM_OUT; i++) begin
            if (mask[i]) begin
                seen++;
                exp_q.push_back({seen == k, data[i*DATA_W +: DATA_W]});
                exp8_q.push_back({seen == k, data[i*DATA_W +: DATA_W]});
            end
        end
    endtask

    task automatic cycle(input logic e, input logic [NUM_OUT-1:0] a, input logic [DW-1:0] d,
                         input logic r, input bit stored);
        en = e;
        out_aktv = a;
        out_data = d;
        m_ready = r;
        if (e && |a) begin
            if (stored) begin
                expect_record(ts_model, a, d, drop_model);
                drop_model = 8'd0;
            end else if (drop_model != 8'hFF) begin
                drop_model = drop_model + 8'd1;
            end
        end
        if (e)
            ts_model = ts_model + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_wait(input int budget, input bit rnd, output bit ok);
        int c;
        c = 0;
        while (got_q.size() < exp_q.size() && c < budget) begin
            cycle(1'b1, '0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            c++;
        end
        ok = (got_q.size() >= exp_q.size());
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = 1'b0;
        out_aktv = '0;
        m_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        got_q.delete();
        got8_q.delete();
        exp_q.delete();
        exp8_q.delete();
        ts_model = '0;
        drop_model = '0;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset m_valid: got %b want 0", m_valid); end
        n_checks++;
        if (m_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset m_last: got %b want 0", m_last); end
        n_checks++;
        if (m_data !== 64'd0) begin n_fail++; $display("[TB] FAIL reset m_data: got %h want 0", m_data); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset overflow: got %b want 0", overflow); end
        rst = 1'b1;
        ts_model = '0;
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        bit ok;
        repeat (500) cycle(1'b1, '0, '0, 1'b1, 1'b0);
        d = rand_data();
        d[0 +: 64] = 64'hFFFF_FFFF_FFFF_FFFD;
        d[128 +: 64] = 64'd7;
        cycle(1'b1, 4'b0101, d, 1'b1, 1'b1);
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single latency N: m_valid %b want 0", m_valid); end
        cycle(1'b1, '0, '0, 1'b1, 1'b0);
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single latency N+1: m_valid %b want 0", m_valid); end
        cycle(1'b1, '0, '0, 1'b1, 1'b0);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 64'h0000_01F4_0002_0005) begin
            n_fail++;
            $display("[TB] FAIL single header N+2: valid %b data %h want 1 000001f400020005", m_valid, m_data);
        end
        drain_wait(50, 1'b0, ok);
        n_checks++;
        if (!ok || got_q.size() != 3) begin n_fail++; $display("[TB] FAIL single count: got %0d words want 3", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[1] !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFD}) begin n_fail++; $display("[TB] FAIL single word1: got %h want 0fffffffffffffffd", got_q[1]); end
            n_checks++;
            if (got_q[2] !== {1'b1, 64'd7}) begin n_fail++; $display("[TB] FAIL single word2: got %h want 10000000000000007", got_q[2]); end
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("[TB] FAIL single word%0d: missing, want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL single word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_hold();
        logic [65:0] snap;
        bit ok;
        int c;
        got_q.delete();
        exp_q.delete();
        cycle(1'b1, 4'b1111, rand_data(), 1'b0, 1'b1);
        c = 0;
        while (!m_valid && c < 10) begin cycle(1'b1, '0, '0, 1'b0, 1'b0); c++; end
        n_checks++;
        if (m_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold header wait: m_valid %b want 1", m_valid); end
        cycle(1'b1, '0, '0, 1'b1, 1'b0);
        m_ready = 1'b0;
        snap = {m_valid, m_last, m_data};
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, '0, '0, 1'b0, 1'b0);
            n_checks++;
            if ({m_valid, m_last, m_data} !== snap) begin
                n_fail++;
                $display("[TB] FAIL hold stall%0d: got %h want %h", i, {m_valid, m_last, m_data}, snap);
            end
        end
        drain_wait(50, 1'b0, ok);
        n_checks++;
        if (!ok || got_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL hold count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("[TB] FAIL hold word%0d: missing, want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL hold word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    // Bursts of at most DEPTH+1 captures from an idle, drained collector never overflow.
    task automatic test_random();
        bit ok;
        int caps;
        logic e;
        logic [NUM_OUT-1:0] a;
        got_q.delete();
        exp_q.delete();
        for (int b = 0; b < 5; b++) begin
            caps = 0;
            for (int i = 0; i < 40; i++) begin
                e = ($urandom_range(0, 3) != 0);
                a = ($urandom_range(0, 2) == 0) ? '0 : NUM_OUT'($urandom);
                if (e && |a) begin
                    if (caps == DEPTH + 1) a = '0;
                    else caps++;
                end
                cycle(e, a, rand_data(), 1'($urandom_range(0, 1)), 1'b1);
            end
            drain_wait(3000, 1'b1, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("[TB] FAIL random drain burst%0d: got %0d words want %0d", b, got_q.size(), exp_q.size()); end
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL random count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("[TB] FAIL random word%0d: missing, want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL random word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_enable();
        logic [31:0] t0;
        bit ok;
        got_q.delete();
        exp_q.delete();
        t0 = ts_model;
        for (int i = 0; i < 50; i++)
            cycle(1'b0, NUM_OUT'($urandom_range(1, 15)), rand_data(), 1'b1, 1'b1);
        n_checks++;
        if (got_q.size() != 0 || m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL enable frozen: got %0d words valid %b want 0 0", got_q.size(), m_valid); end
        cycle(1'b1, 4'b0010, rand_data(), 1'b1, 1'b1);
        drain_wait(50, 1'b0, ok);
        n_checks++;
        if (!ok || got_q.size() != 2) begin n_fail++; $display("[TB] FAIL enable count: got %0d want 2", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0][63:32] !== t0) begin n_fail++; $display("[TB] FAIL enable resume ts: got %0d want %0d", got_q[0][63:32], t0); end
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("[TB] FAIL enable word%0d: missing, want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL enable word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    // Record A parks in the serializer so the FIFO alone absorbs the burst.
    task automatic test_overflow(input int n_drop, input logic [7:0] want_drops);
        bit ok;
        int base;
        do_reset();
        cycle(1'b1, 4'b0001, rand_data(), 1'b0, 1'b1);
        repeat (3) cycle(1'b1, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, NUM_OUT'($urandom_range(1, 15)), rand_data(), 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf%0d early overflow: got %b want 0", n_drop, overflow); end
        for (int i = 0; i < n_drop; i++)
            cycle(1'b1, NUM_OUT'($urandom_range(1, 15)), rand_data(), 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf%0d overflow: got %b want 1", n_drop, overflow); end
        drain_wait(500, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL ovf%0d drain: got %0d want %0d", n_drop, got_q.size(), exp_q.size()); end
        base = exp_q.size();
        cycle(1'b1, 4'b0011, rand_data(), 1'b1, 1'b1);
        cycle(1'b1, 4'b1000, rand_data(), 1'b1, 1'b1);
        drain_wait(100, 1'b0, ok);
        n_checks++;
        if (!ok || got_q.size() != base + 5) begin n_fail++; $display("[TB] FAIL ovf%0d count: got %0d want %0d", n_drop, got_q.size(), base + 5); end
        else begin
            n_checks++;
            if (got_q[base][31:24] !== want_drops) begin n_fail++; $display("[TB] FAIL ovf%0d drops: got %0d want %0d", n_drop, got_q[base][31:24], want_drops); end
            n_checks++;
            if (got_q[base+3][31:24] !== 8'd0) begin n_fail++; $display("[TB] FAIL ovf%0d drops cleared: got %0d want 0", n_drop, got_q[base+3][31:24]); end
        end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf%0d sticky: got %b want 1", n_drop, overflow); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("[TB] FAIL ovf%0d word%0d: missing, want %h", n_drop, i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL ovf%0d word%0d: got %h want %h", n_drop, i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        int c;
        do_reset();
        cycle(1'b1, 4'b0111, rand_data(), 1'b1, 1'b1);
        c = 0;
        while (got_q.size() < 2 && c < 20) begin cycle(1'b1, '0, '0, 1'b1, 1'b0); c++; end
        m_ready = 1'b0;
        #2;
        n_checks++;
        if (m_valid !== 1'b1 || got_q.size() != 2) begin n_fail++; $display("[TB] FAIL abort setup: valid %b words %0d want 1 2", m_valid, got_q.size()); end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({m_valid, m_last, m_data} !== 66'd0) begin n_fail++; $display("[TB] FAIL abort async clear: got %b %b %h want 0 0 0", m_valid, m_last, m_data); end
        do_reset();
        repeat (10) cycle(1'b1, '0, '0, 1'b1, 1'b0);
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("[TB] FAIL abort residual: got %0d words want 0", got_q.size()); end
        cycle(1'b1, 4'b1000, rand_data(), 1'b1, 1'b1);
        drain_wait(50, 1'b0, ok);
        n_checks++;
        if (!ok || got_q.size() != 2) begin n_fail++; $display("[TB] FAIL abort count: got %0d want 2", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0][63:32] !== 32'd10) begin n_fail++; $display("[TB] FAIL abort ts: got %0d want 10", got_q[0][63:32]); end
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("[TB] FAIL abort word%0d: missing, want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL abort word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ts_wrap();
        bit ok;
        do_reset();
        repeat (254) cycle(1'b1, '0, '0, 1'b1, 1'b0);
        cycle(1'b1, 4'b0001, rand_data(), 1'b1, 1'b1);
        cycle(1'b1, 4'b0010, rand_data(), 1'b1, 1'b1);
        cycle(1'b1, 4'b0100, rand_data(), 1'b1, 1'b1);
        drain_wait(100, 1'b0, ok);
        n_checks++;
        if (!ok || got8_q.size() != 6) begin n_fail++; $display("[TB] FAIL wrap count: got %0d want 6", got8_q.size()); end
        else begin
            n_checks++;
            if (got8_q[2][63:32] !== 32'd255) begin n_fail++; $display("[TB] FAIL wrap ts255: got %0d want 255", got8_q[2][63:32]); end
            n_checks++;
            if (got8_q[4][63:32] !== 32'd0) begin n_fail++; $display("[TB] FAIL wrap ts0: got %0d want 0", got8_q[4][63:32]); end
        end
        foreach (exp8_q[i]) begin
            n_checks++;
            if (i >= got8_q.size()) begin n_fail++; $display("[TB] FAIL wrap8 word%0d: missing, want %h", i, exp8_q[i]); end
            else if (got8_q[i] !== exp8_q[i]) begin n_fail++; $display("[TB] FAIL wrap8 word%0d: got %h want %h", i, got8_q[i], exp8_q[i]); end
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size()) begin n_fail++; $display("[TB] FAIL wrap32 word%0d: missing, want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL wrap32 word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        $display("[TB] verdict_collector bench start");
        test_reset();
        test_single();
        test_hold();
        test_random();
        test_enable();
        test_overflow(2, 8'd2);
        test_overflow(300, 8'd255);
        test_reset_abort();
        test_ts_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
